// File: rtl/reg_file.sv
// rtl/reg_file.sv - MIPS register file, 2 combinational read ports, 1 synchronous write port.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] read_reg1,
    input  logic [ADDR_BITS-1:0] read_reg2,
    input  logic [ADDR_BITS-1:0] write_reg,
    input  logic [WIDTH-1:0]     write_data,
    input  logic                 reg_write,
    output logic [WIDTH-1:0]     read_data1,
    output logic [WIDTH-1:0]     read_data2
);
    localparam int NUM_REGS = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] w_stored1;
    logic [WIDTH-1:0] w_stored2;
    logic             w_wr_en;

    // r0 is excluded from writes so it can never hold anything but zero
    assign w_wr_en = reg_write & (write_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    assign w_stored1 = (read_reg1 == '0) ? '0 : r_regs[read_reg1];
    assign w_stored2 = (read_reg2 == '0) ? '0 : r_regs[read_reg2];

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // Forward the in-flight writeback; suppressed during reset since that write is dropped
    assign w_hit1 = ~rst & w_wr_en & (read_reg1 == write_reg);
    assign w_hit2 = ~rst & w_wr_en & (read_reg2 == write_reg);

    assign read_data1 = w_hit1 ? write_data : w_stored1;
    assign read_data2 = w_hit2 ? write_data : w_stored2;
`else
    assign read_data1 = w_stored1;
    assign read_data2 = w_stored2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file, both REGFILE_BYPASS_EN builds.
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int          pass_cnt;
    int          total_cnt;

    reg_file #(.WIDTH(32), .ADDR_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = a;
        write_data = d;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
        write_data = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        reg_write  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (read_data1 !== exp_v) $display("FAIL reset_rd1[%0d]: got %h want %h", i, read_data1, exp_v);
            else pass_cnt++;
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (read_data2 !== exp_v) $display("FAIL reset_rd2[%0d]: got %h want %h", 31 - i, read_data2, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        read_reg1 = 5'd5;
        do_write(5'd5, 32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL write_r5: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        @(negedge clk);
        reg_write  = 1'b0;
        write_reg  = 5'd5;
        write_data = 32'h0;
        @(posedge clk);
        #1;
        exp_q.push_back(32'hDEADBEEF);
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL hold_r5: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_r0();
        @(negedge clk);
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFFFFFF;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL r0_pre_rd1: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data2 !== exp_v) $display("FAIL r0_pre_rd2: got %h want %h", read_data2, exp_v);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL r0_post_rd1: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data2 !== exp_v) $display("FAIL r0_post_rd2: got %h want %h", read_data2, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h1);
        @(negedge clk);
        read_reg1  = 5'd6;
        read_reg2  = 5'd7;
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h2;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h2);
`else
        exp_q.push_back(32'h1);
`endif
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data2 !== exp_v) $display("FAIL bypass_pre_rd2: got %h want %h", read_data2, exp_v);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL bypass_other_port_rd1: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
        write_data = '0;
        exp_q.push_back(32'h2);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data2 !== exp_v) $display("FAIL bypass_post_rd2: got %h want %h", read_data2, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset_priority();
        read_reg1 = 5'd3;
        do_write(5'd3, 32'h55);
        exp_q.push_back(32'h55);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL rstpri_setup: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        @(negedge clk);
        rst        = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'hAA;
        exp_q.push_back(32'h55);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL rstpri_pre_nobypass: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        reg_write  = 1'b0;
        write_data = '0;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL rstpri_post: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v31;
        logic [31:0] v1;
        v31 = $urandom;
        v1  = $urandom;
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'd31;
        write_data = v31;
        @(posedge clk);
        #1;
        write_reg  = 5'd1;
        write_data = v1;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
        write_data = '0;
        read_reg1  = 5'd31;
        read_reg2  = 5'd1;
        exp_q.push_back(v31);
        exp_q.push_back(v1);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL b2b_r31: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data2 !== exp_v) $display("FAIL b2b_r1: got %h want %h", read_data2, exp_v);
        else pass_cnt++;
        read_reg1 = 5'd1;
        read_reg2 = 5'd1;
        exp_q.push_back(v1);
        exp_q.push_back(v1);
        #1;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data1 !== exp_v) $display("FAIL same_addr_rd1: got %h want %h", read_data1, exp_v);
        else pass_cnt++;
        exp_v = exp_q.pop_front();
        total_cnt++;
        if (read_data2 !== exp_v) $display("FAIL same_addr_rd2: got %h want %h", read_data2, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst        = 1'b1;
        read_reg1  = '0;
        read_reg2  = '0;
        write_reg  = '0;
        write_data = '0;
        reg_write  = 1'b0;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_reset_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
